// File: rtl/synth_pkg.sv
// Shared constants and helpers for the pocket synth: note frequencies,
// half-period computation, arpeggiator state encoding and note selection.
package synth_pkg;

  localparam int HP_W = 24;

  localparam int F_C4 = 262;
  localparam int F_E4 = 330;
  localparam int F_G4 = 392;
  localparam int F_B4 = 494;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } arp_state_t;

  function automatic logic [HP_W-1:0] half_period(input int clk_freq, input logic [1:0] idx);
    logic [HP_W-1:0] hp;
    case (idx)
      2'd0:    hp = HP_W'(clk_freq / (2 * F_C4));
      2'd1:    hp = HP_W'(clk_freq / (2 * F_E4));
      2'd2:    hp = HP_W'(clk_freq / (2 * F_G4));
      default: hp = HP_W'(clk_freq / (2 * F_B4));
    endcase
    return hp;
  endfunction

  function automatic logic [1:0] lowest_bit(input logic [3:0] mask);
    logic [1:0] res;
    res = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) res = 2'(i);
    end
    return res;
  endfunction

  // Lowest set bit strictly above cur, wrapping to the lowest set bit overall.
  function automatic logic [1:0] next_note(input logic [3:0] mask, input logic [1:0] cur);
    logic [1:0] res;
    logic       found;
    res   = lowest_bit(mask);
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        res   = 2'(i);
        found = 1'b1;
      end
    end
    if (!found) res = lowest_bit(mask);
    return res;
  endfunction

endpackage

// File: rtl/tone_osc.sv
// Square-wave tone oscillator; held at phase 0 / level low while not running
// so every note starts from the same point.
import synth_pkg::*;

module tone_osc (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [HP_W-1:0] half_period,
  input  logic            run,
  output logic            tone
);

  logic [HP_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == half_period - HP_W'(1)) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + HP_W'(1);
    end
  end

endmodule

// File: rtl/arp_sequencer.sv
// Four-key arpeggiator: key sync, step scheduler FSM and one tone oscillator.
// Optional ARP_LATCH_EN keeps released keys sounding until enable drops.
import synth_pkg::*;

module arp_sequencer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int STEP_HZ  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] keys,
  input  logic       enable,
  output logic       audio_out,
  output logic       gate,
  output logic [1:0] note_idx,
  output logic [3:0] leds
);

  localparam int STEP_CYCLES = CLK_FREQ / STEP_HZ;
  localparam int GATE_CYCLES = (STEP_CYCLES * 3) / 4;
  localparam int CNT_W       = $clog2(STEP_CYCLES);

  logic [3:0] key_meta, key_sync, mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= keys;
      key_sync <= key_meta;
    end
  end

`ifdef ARP_LATCH_EN
  logic [3:0] latch, prev_sync;

  // A press after a full release starts a fresh chord; otherwise keys accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch     <= '0;
      prev_sync <= '0;
    end else begin
      prev_sync <= key_sync;
      if (!enable)
        latch <= '0;
      else if ((key_sync != 4'd0) && (prev_sync == 4'd0))
        latch <= key_sync;
      else
        latch <= latch | key_sync;
    end
  end

  assign mask = latch;
`else
  assign mask = key_sync;
`endif

  assign leds = mask;

  arp_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       note_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      note_idx <= 2'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      note_idx <= note_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    note_n  = note_idx;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (mask != 4'd0) begin
            note_n  = lowest_bit(mask);
            state_n = PLAY;
          end
        end
        PLAY: begin
          if (mask == 4'd0) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(GATE_CYCLES - 1)) state_n = GAP;
          end
        end
        GAP: begin
          if (cnt == CNT_W'(STEP_CYCLES - 1)) begin
            cnt_n = '0;
            if (mask == 4'd0) begin
              state_n = IDLE;
            end else begin
              note_n  = next_note(mask, note_idx);
              state_n = PLAY;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign gate = (state == PLAY);

  logic tone;

  tone_osc u_tone_osc (
    .clk         (clk),
    .rst_n       (rst_n),
    .half_period (half_period(CLK_FREQ, note_idx)),
    .run         (gate),
    .tone        (tone)
  );

  assign audio_out = tone & gate;

endmodule

// File: tb/tb_arp_sequencer.sv
// Self-checking bench for arp_sequencer at a reduced clock (1000-cycle steps);
// expected notes are queued when keys are driven and checked at each gate rise.
module tb_arp_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] keys;
  logic       enable;
  logic       audio_out;
  logic       gate;
  logic [1:0] note_idx;
  logic [3:0] leds;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [1:0] exp_q[$];
  int hp_tab[4] = '{190, 151, 127, 101};

  arp_sequencer #(.CLK_FREQ(100_000), .STEP_HZ(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keys      (keys),
    .enable    (enable),
    .audio_out (audio_out),
    .gate      (gate),
    .note_idx  (note_idx),
    .leds      (leds)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // driver / wait tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(input int budget, output int n, output bit ok);
    logic p;
    p  = gate;
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (gate && !p) ok = 1'b1;
      p = gate;
    end
  endtask

  task automatic go_idle();
    keys   = 4'd0;
    enable = 1'b0;
    step(5);
    enable = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    keys   = 4'd0;
    enable = 1'b1;
    step(3);
    total++; if (audio_out !== 1'b0) begin bad++; $display("FAIL reset_audio got=%b exp=0", audio_out); end
    total++; if (gate !== 1'b0) begin bad++; $display("FAIL reset_gate got=%b exp=0", gate); end
    total++; if (note_idx !== 2'd0) begin bad++; $display("FAIL reset_note got=%0d exp=0", note_idx); end
    total++; if (leds !== 4'd0) begin bad++; $display("FAIL reset_leds got=%b exp=0000", leds); end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_single_key();
    int n, t, first_up, second_up, low_n;
    bit ok;
    logic [1:0] exp;
    logic pa;
    keys = 4'b0001;
    exp_q.push_back(2'd0);
    wait_rise(10, n, ok);
    total++; if (!ok || n != 3) begin bad++; $display("FAIL single_latency got=%0d ok=%0b exp=3", n, ok); end
    exp = exp_q.pop_front();
    total++; if (note_idx !== exp) begin bad++; $display("FAIL single_note got=%0d exp=%0d", note_idx, exp); end
    total++; if (leds !== 4'b0001) begin bad++; $display("FAIL single_leds got=%b exp=0001", leds); end
    t = 0; first_up = -1; second_up = -1; pa = audio_out;
    while (gate === 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
      if (audio_out && !pa) begin
        if (first_up < 0) first_up = t;
        else if (second_up < 0) second_up = t;
      end
      pa = audio_out;
    end
    total++; if (t != 750) begin bad++; $display("FAIL single_gate_high got=%0d exp=750", t); end
    total++; if (first_up != 190) begin bad++; $display("FAIL single_first_rise got=%0d exp=190", first_up); end
    total++; if (second_up - first_up != 380) begin bad++; $display("FAIL single_period got=%0d exp=380", second_up - first_up); end
    exp_q.push_back(2'd0);
    wait_rise(400, low_n, ok);
    total++; if (!ok || low_n != 250) begin bad++; $display("FAIL single_gate_low got=%0d ok=%0b exp=250", low_n, ok); end
    exp = exp_q.pop_front();
    total++; if (note_idx !== exp) begin bad++; $display("FAIL single_repeat_note got=%0d exp=%0d", note_idx, exp); end
  endtask

  task automatic test_two_keys();
    int n, t_prev, a;
    bit ok;
    logic [1:0] exp;
    go_idle();
    keys = 4'b1010;
    exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_rise(1100, n, ok);
      total++; if (!ok) begin bad++; $display("FAIL pair_timeout step=%0d", k); end
      if (k == 0) begin
        total++; if (n != 3) begin bad++; $display("FAIL pair_latency got=%0d exp=3", n); end
      end else begin
        total++; if (cyc - t_prev != 1000) begin bad++; $display("FAIL pair_spacing step=%0d got=%0d exp=1000", k, cyc - t_prev); end
      end
      t_prev = cyc;
      exp = exp_q.pop_front();
      total++; if (note_idx !== exp) begin bad++; $display("FAIL pair_note step=%0d got=%0d exp=%0d", k, note_idx, exp); end
      a = 0;
      while (audio_out !== 1'b1 && a < 400) begin @(negedge clk); a++; end
      total++; if (a != hp_tab[exp]) begin bad++; $display("FAIL pair_first_low step=%0d got=%0d exp=%0d", k, a, hp_tab[exp]); end
    end
  endtask

`ifndef ARP_LATCH_EN
  task automatic test_release_all();
    int n;
    bit ok;
    logic [1:0] exp;
    go_idle();
    keys = 4'b0101;
    exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    for (int k = 0; k < 2; k++) begin
      wait_rise(1100, n, ok);
      exp = exp_q.pop_front();
      total++; if (!ok || note_idx !== exp) begin bad++; $display("FAIL release_note step=%0d got=%0d ok=%0b exp=%0d", k, note_idx, ok, exp); end
    end
    step(100);
    keys = 4'd0;
    n = 0;
    while (gate === 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++; if (n > 3 || gate !== 1'b0) begin bad++; $display("FAIL release_gate_off got=%0d exp<=3", n); end
    total++; if (dut.state !== 2'd0) begin bad++; $display("FAIL release_state got=%0d exp=0", dut.state); end
    total++; if (audio_out !== 1'b0) begin bad++; $display("FAIL release_audio got=%b exp=0", audio_out); end
  endtask
`endif

  task automatic test_enable();
    int n, highs;
    bit ok;
    logic [1:0] exp;
    go_idle();
    keys = 4'b0011;
    exp_q.push_back(2'd0);
    wait_rise(10, n, ok);
    exp = exp_q.pop_front();
    total++; if (!ok || note_idx !== exp) begin bad++; $display("FAIL enable_first_note got=%0d ok=%0b exp=%0d", note_idx, ok, exp); end
    n = 0;
    while (gate === 1'b1 && n < 800) begin @(negedge clk); n++; end
    step(50);
    enable = 1'b0;
    highs = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (gate === 1'b1) highs++;
    end
    total++; if (highs != 0) begin bad++; $display("FAIL enable_low_gate got=%0d exp=0", highs); end
    enable = 1'b1;
    exp_q.push_back(2'd0);
    wait_rise(5, n, ok);
    total++; if (!ok || n != 1) begin bad++; $display("FAIL enable_restart_latency got=%0d ok=%0b exp=1", n, ok); end
    exp = exp_q.pop_front();
    total++; if (note_idx !== exp) begin bad++; $display("FAIL enable_restart_note got=%0d exp=%0d", note_idx, exp); end
  endtask

  task automatic test_async_reset();
    int n;
    bit ok;
    step(300);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (gate !== 1'b0 || audio_out !== 1'b0 || leds !== 4'd0 || note_idx !== 2'd0)
      begin bad++; $display("FAIL async_reset got gate=%b audio=%b leds=%b note=%0d exp=0", gate, audio_out, leds, note_idx); end
    step(3);
    rst_n = 1'b1;
    exp_q.push_back(2'd0);
    wait_rise(10, n, ok);
    total++; if (!ok || n != 3) begin bad++; $display("FAIL async_resync got=%0d ok=%0b exp=3", n, ok); end
    begin
      logic [1:0] exp;
      exp = exp_q.pop_front();
      total++; if (note_idx !== exp) begin bad++; $display("FAIL async_note got=%0d exp=%0d", note_idx, exp); end
    end
  endtask

`ifdef ARP_LATCH_EN
  task automatic test_latch();
    int n;
    bit ok;
    logic [1:0] exp;
    go_idle();
    keys = 4'b0011;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    for (int k = 0; k < 3; k++) begin
      wait_rise(1100, n, ok);
      exp = exp_q.pop_front();
      total++; if (!ok || note_idx !== exp) begin bad++; $display("FAIL latch_note step=%0d got=%0d ok=%0b exp=%0d", k, note_idx, ok, exp); end
      if (k == 0) begin step(100); keys = 4'd0; end
    end
    total++; if (leds !== 4'b0011) begin bad++; $display("FAIL latch_leds_hold got=%b exp=0011", leds); end
    step(100);
    keys = 4'b1000;
    exp_q.push_back(2'd3); exp_q.push_back(2'd3);
    for (int k = 0; k < 2; k++) begin
      wait_rise(1100, n, ok);
      exp = exp_q.pop_front();
      total++; if (!ok || note_idx !== exp) begin bad++; $display("FAIL latch_new_note step=%0d got=%0d ok=%0b exp=%0d", k, note_idx, ok, exp); end
    end
    total++; if (leds !== 4'b1000) begin bad++; $display("FAIL latch_leds_new got=%b exp=1000", leds); end
  endtask
`endif

  // scenario sequence and final report
  initial begin
    test_reset();
    test_single_key();
    test_two_keys();
`ifndef ARP_LATCH_EN
    test_release_all();
`endif
    test_enable();
    test_async_reset();
`ifdef ARP_LATCH_EN
    test_latch();
`endif
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arp_sequencer.md
# arp_sequencer

Four-key arpeggiator that sequences the pocket synth's single square-wave tone datapath. It repeatedly steps through the currently held keys (C4, E4, G4, B4) in ascending order at a fixed tempo. Each step is a gated note followed by a short silence. The block sits between the key buttons and the speaker pin. It owns input synchronization, the step scheduler state machine and one tone oscillator instance.

## Interface
- CLK_FREQ, 50_000_000, system clock in Hz
- STEP_HZ, 8, arpeggio steps per second; STEP_CYCLES = CLK_FREQ/STEP_HZ, GATE_CYCLES = (STEP_CYCLES*3)/4 (integer division)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- keys  in  4  raw key buttons, active-high, asynchronous; bit 0 = C4 … bit 3 = B4
- enable  in  1  synchronous run enable; low forces silence
- audio_out  out  1  square wave, low whenever gate is low
- gate  out  1  high while a note sounds
- note_idx  out  2  index of the current/last note
- leds  out  4  active key mask (synchronized or latched)

## Operation
- Keys pass through a 2-flop synchronizer per bit (reset 0). Without the latch feature, the active mask = synchronized keys.
- Half periods per note are CLK_FREQ/(2*f), with f = 262, 330, 392, 494 Hz, held in 24-bit values.
- FSM states:
  - IDLE: gate 0, step counter 0. If enable && mask != 0, load note_idx with the lowest set bit, clear the counter, go to PLAY.
  - PLAY: gate 1, counter increments. At counter == GATE_CYCLES-1, go to GAP. If the mask becomes 0, go to IDLE on the next clock. Releasing only the current key does not cut the note.
  - GAP: gate 0, counter continues. At counter == STEP_CYCLES-1:
    - Mask 0 → IDLE.
    - Otherwise note_idx = lowest set bit strictly above the current note_idx, wrapping to the lowest set bit; counter 0; go to PLAY.
    - A single held key repeats.
- enable low in any state → IDLE next clock, gate 0, latch cleared.
- The tone oscillator runs only in PLAY. Its counter and tone are cleared whenever it is not running, so every note starts at phase 0, level low. It toggles at count half_period-1.
- audio_out = tone AND gate.
- Reset values: audio_out 0, gate 0, note_idx 0, leds 0, FSM IDLE, all counters 0.

## Timing
- Key edge → synchronized mask: 2 clocks. Mask → gate high: +1 clock (IDLE→PLAY registered).
- Gate is high for exactly GATE_CYCLES clocks and low for STEP_CYCLES-GATE_CYCLES clocks per step. Step period is exactly STEP_CYCLES.
- First audio_out rise occurs half_period clocks after gate rises.
- note_idx changes on the same clock gate rises. It holds through the GAP.
- Reset asserted mid-note: all outputs 0 immediately (asynchronous).

## Configuration
- ARP_LATCH_EN defined: pressed keys OR into a latch register.
  - Releasing all keys keeps the latch, so the arpeggio continues until enable goes low.
  - The first press after all keys were released clears the latch and loads the new keys.
  - Active mask and leds = latch.
- ARP_LATCH_EN undefined: no latch register; the mask follows the synchronized keys. Releasing all keys silences the output per the FSM rules.

## Structure
- synth_pkg: note frequency constants and the half-period function.
- synth_pkg: arp_state_t enum {IDLE, PLAY, GAP}.
- synth_pkg: 24-bit half-period width constant.
- Sub-module tone_osc: half_period and run inputs, tone output. It is instantiated once.
- The lowest-set-bit-above search is a combinational function in the package.

## Test plan
Use CLK_FREQ=100_000, STEP_HZ=100 (STEP 1000, GATE 750, half periods C4 190, E4 151, G4 127, B4 101) for all scenarios.
- Reset with keys=0 → all outputs 0. Hold keys=4'b0001 → gate rises 3 clocks later, note_idx 0, audio_out period 380 clocks, gate high 750 / low 250.
- keys=4'b1010 held → note_idx sequence 1,3,1,3 at 1000-clock spacing. Each note starts with audio_out low for its half period.
- keys=4'b0101 → note_idx 0 then 2; release all mid-PLAY → gate 0 within 3 clocks, FSM IDLE, audio_out 0.
- Lower enable mid-GAP with keys held → gate stays 0. Raise enable → restart from the lowest key.
- Assert rst_n low mid-note → audio_out, gate and leds drop the same cycle. Release reset → a new note starts only after resynchronization.
- ARP_LATCH_EN: press 4'b0011 then release all → arpeggio continues 0,1,0. Press 4'b1000 → only note 3 repeats.
